// File: rtl/input_conditioner.sv
// input_conditioner: four-channel switch front end.
// Each raw input is passed through a two-flop synchronizer and then a
// per-channel debounce counter. a/b/c/d are the registered stable levels.
// Optional feature macro: INPUT_CONDITIONER_EDGE_EN adds registered
// one-cycle rise/fall pulses per channel.
module input_conditioner #(
    parameter  int unsigned DEBOUNCE_CYCLES = 500000,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
`ifdef INPUT_CONDITIONER_EDGE_EN
    ,
    output logic [3:0] rise,
    output logic [3:0] fall
`endif
);

    // Terminal count: the stable level commits on the edge where the
    // counter already holds DEBOUNCE_CYCLES-1, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];

    logic [3:0]       w_stable_next;
    logic [CNT_W-1:0] w_cnt_next [4];

    // Two-flop synchronizer per channel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce decision: a matching sample clears the count, a mismatch
    // counts up until the window expires and the stable level commits
    always_comb begin
        w_stable_next = r_stable;
        for (int unsigned i = 0; i < 4; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter and stable-level registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_next;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign a = r_stable[0];
    assign b = r_stable[1];
    assign c = r_stable[2];
    assign d = r_stable[3];

`ifdef INPUT_CONDITIONER_EDGE_EN
    logic [3:0] r_rise;
    logic [3:0] r_fall;

    // Edge pulses registered on the same edge the stable level changes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_stable_next & ~r_stable;
            r_fall <= ~w_stable_next & r_stable;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner with DEBOUNCE_CYCLES=4 (plus a second
// instance at DEBOUNCE_CYCLES=1 for the minimum-window case).
module tb_input_conditioner;

    logic       clock;
    logic       reset_n;
    logic [3:0] sw_in;
    logic       a, b, c, d;
    logic       a1, b1, c1, d1;
    logic [3:0] w_out, w_out1;
`ifdef INPUT_CONDITIONER_EDGE_EN
    logic [3:0] rise, fall, rise1, fall1;
`endif

    int errors = 0;
    int checks = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sw_in   (sw_in),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d)
`ifdef INPUT_CONDITIONER_EDGE_EN
        ,
        .rise    (rise),
        .fall    (fall)
`endif
    );

    input_conditioner #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .sw_in   (sw_in),
        .a       (a1),
        .b       (b1),
        .c       (c1),
        .d       (d1)
`ifdef INPUT_CONDITIONER_EDGE_EN
        ,
        .rise    (rise1),
        .fall    (fall1)
`endif
    );

    assign w_out  = {d, c, b, a};
    assign w_out1 = {d1, c1, b1, a1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] sw;
        int         edges;
        logic [3:0] exp_out;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    vec_t vec [13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // {sw, edges to advance, expected {d,c,b,a}, expected rise, expected fall}
        vec[0]  = '{4'b0000, 5, 4'b1111, 4'b0000, 4'b0000}; // release all, edge k+4
        vec[1]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b1111}; // all fall at k+5
        vec[2]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000}; // fall pulse gone
        vec[3]  = '{4'b0010, 5, 4'b0000, 4'b0000, 4'b0000}; // press b, not yet at k+4
        vec[4]  = '{4'b0010, 1, 4'b0010, 4'b0010, 4'b0000}; // b=1 at k+5
        vec[5]  = '{4'b0010, 1, 4'b0010, 4'b0000, 4'b0000}; // rise one cycle only
        vec[6]  = '{4'b0110, 3, 4'b0010, 4'b0000, 4'b0000}; // c high 3 cycles
        vec[7]  = '{4'b0010, 1, 4'b0010, 4'b0000, 4'b0000}; // c glitch low
        vec[8]  = '{4'b0110, 5, 4'b0010, 4'b0000, 4'b0000}; // c held, k'+4 not yet
        vec[9]  = '{4'b0110, 1, 4'b0110, 4'b0100, 4'b0000}; // c=1 at k'+5
        vec[10] = '{4'b0111, 2, 4'b0110, 4'b0000, 4'b0000}; // a starts first
        vec[11] = '{4'b1111, 4, 4'b0111, 4'b0001, 4'b0000}; // a commits on its own count
        vec[12] = '{4'b1111, 2, 4'b1111, 4'b1000, 4'b0000}; // d commits two edges later

        // Reset held with all switches high
        reset_n = 1'b0;
        sw_in   = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check4("reset_out", w_out, 4'b0000);
`ifdef INPUT_CONDITIONER_EDGE_EN
            check4("reset_rise", rise, 4'b0000);
            check4("reset_fall", fall, 4'b0000);
`endif
        end

        // Release: window 4 commits at edge 6, window 1 at edge 3
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check4("rel_pending", w_out, 4'b0000);
            check4("rel_dc1", w_out1, (i >= 3) ? 4'b1111 : 4'b0000);
        end
        tick();
        check4("rel_edge6", w_out, 4'b1111);
`ifdef INPUT_CONDITIONER_EDGE_EN
        check4("rel_rise6", rise, 4'b1111);
`endif
        tick();
        check4("rel_edge7", w_out, 4'b1111);
`ifdef INPUT_CONDITIONER_EDGE_EN
        check4("rel_rise7", rise, 4'b0000);
`endif

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            sw_in = vec[v].sw;
            repeat (vec[v].edges) tick();
            check4($sformatf("vec%0d_out", v), w_out, vec[v].exp_out);
`ifdef INPUT_CONDITIONER_EDGE_EN
            check4($sformatf("vec%0d_rise", v), rise, vec[v].exp_rise);
            check4($sformatf("vec%0d_fall", v), fall, vec[v].exp_fall);
`endif
        end

        // Reset in the middle of a d debounce
        sw_in = 4'b0111;
        repeat (6) tick();
        check4("mid_pre", w_out, 4'b0111);
        sw_in = 4'b1111;
        repeat (4) tick();              // two sync edges + two counting edges
        check4("mid_counting", w_out, 4'b0111);
        #2 reset_n = 1'b0;
        #1;
        check4("mid_async_clear", w_out, 4'b0000);
        check4("mid_async_clear1", w_out1, 4'b0000);
        #1 reset_n = 1'b1;
        repeat (5) tick();
        check4("mid_after5", w_out, 4'b0000);
        tick();
        check4("mid_after6", w_out, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

- Upstream stage for the four-input logic network (inputs a, b, c, d → outputs x, y, z).
- Takes four raw, asynchronous switch/button signals and synchronizes each one to the system clock.
- Debounces each channel independently and presents stable, registered a, b, c, d levels to the network.
- Optionally provides one-cycle rising/falling edge pulses per channel.

## Interface
- DEBOUNCE_CYCLES, default 500000 — consecutive cycles a synchronized input must differ from the stable output before the output follows it (10 ms at 50 MHz); legal range ≥ 1.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1) — debounce counter width; derived, never overridden.
- clock  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- sw_in  input  4  raw asynchronous switch levels; sw_in[0]→a, [1]→b, [2]→c, [3]→d.
- a, b, c, d  output  1 each  debounced, registered levels.
- rise  output  4  one-cycle pulse when the channel's stable level goes 0→1 (present only with INPUT_CONDITIONER_EDGE_EN).
- fall  output  4  one-cycle pulse when the channel's stable level goes 1→0 (present only with INPUT_CONDITIONER_EDGE_EN).

## Operation
- Per channel i, there are four state elements:
  - sync1[i] and sync2[i]: a two-flop synchronizer.
  - cnt[i]: a CNT_W-bit counter.
  - stable[i]: the output register.
- Reset (reset_n low, asynchronous): sync1, sync2, cnt, stable, rise and fall all go to 0, so a=b=c=d=0. Reset overrides everything, including mid-debounce; partial counts are discarded.
- Each rising edge, per channel, when not in reset:
  - sync1 ← sw_in[i]; sync2 ← sync1.
  - If sync2 == stable: cnt ← 0 (a glitch shorter than the window restarts the count).
  - Else if cnt == DEBOUNCE_CYCLES−1: stable ← sync2, cnt ← 0.
  - Else: cnt ← cnt+1.
- Implicit per-channel states: IDLE (cnt=0, sync2==stable) and COUNTING (sync2≠stable). COUNTING returns to IDLE either on a mismatch clearing (stable unchanged) or on window expiry (stable toggles).
- Channels are fully independent. Simultaneous changes on several channels debounce in parallel, and each commits on its own count.
- cnt never exceeds DEBOUNCE_CYCLES−1; there is no wrap-around.
- With DEBOUNCE_CYCLES=1, stable follows sync2 with one cycle of delay.

## Timing
- Latency: sw_in changes before edge k and then holds → stable/output updates at edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 rising edges counting edge k.
- Any return of sync2 to the old stable value before commit resets cnt. The full window is then required again from the next change.
- Outputs are pure register outputs with no combinational path from sw_in.
- After reset release with sw_in[i]=1 held, output i rises at the (DEBOUNCE_CYCLES+2)th rising edge after release.
- rise/fall are registered on the same edge stable changes. They are high for exactly one cycle, coincident with the first cycle of the new level, and never both high on the same channel.

## Configuration
- INPUT_CONDITIONER_EDGE_EN defined:
  - rise[3:0] and fall[3:0] ports and their registers exist.
  - rise[i] ← stable_next[i] & ~stable[i]; fall[i] ← ~stable_next[i] & stable[i].
- Not defined:
  - Ports and registers are absent.
  - a, b, c, d behaviour and timing are identical.

## Test plan
- Reset: hold reset_n=0 with sw_in=4'b1111 for 10 cycles → a=b=c=d=0, rise=fall=0 throughout. Release with DEBOUNCE_CYCLES=4 → all four outputs 1 at the 6th rising edge after release; rise=4'b1111 for exactly that one cycle.
- Clean press, DEBOUNCE_CYCLES=4: sw_in[1] 0→1 before edge k and held → b=1 from edge k+5, not at k+4; rise[1] pulses one cycle; a, c, d stay 0.
- Bounce: sw_in[2] toggles 1,0,1 with the high phases lasting 3 cycles → c stays 0. Then held high 4+ cycles after the last toggle → c=1 exactly 5 edges after the final 0→1 transition.
- Release and simultaneous channels: from sw_in=4'b1111 stable, drive 4'b0000 → a..d fall together at edge k+5; fall=4'b1111 for one cycle.
- Reset mid-debounce: sw_in[3] rises and reset_n is pulsed low asynchronously (between edges) after 2 cycles of counting → d=0 immediately, cnt cleared. After release, d=1 only 6 edges later.
- Build without INPUT_CONDITIONER_EDGE_EN: rerun the clean-press scenario → identical a..d waveforms, and rise/fall are not present in the elaborated design.
